aes_spi_sequencer: RTL and testbench

//  Drives the SPI master (byte interface: start/buzy/done/data_in/data_out) through one full AES

---
 rtl/aes_spi_sequencer.sv | 158 +++++++++++++++
 tb/tb_aes_spi_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_sequencer.sv
// Sequences one AES transaction over a byte-wide SPI master: text block, key-size byte, key,
// then dummy bytes while the result block is shifted in.
module aes_spi_sequencer #(
  parameter int unsigned TEXT_BYTES = 16,
  parameter int unsigned KEY_MAX    = 32,
  parameter logic [7:0]  DUMMY_BYTE = 8'h00
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic [7:0]                key_size_i,
  input  logic [TEXT_BYTES*8-1:0]   text_in_i,
  input  logic [KEY_MAX*8-1:0]      key_in_i,
  output logic                      busy_o,
  output logic                      result_valid_o,
  output logic [TEXT_BYTES*8-1:0]   result_o,
  output logic                      err_o,
  output logic                      spi_start_o,
  output logic [7:0]                spi_tx_o,
  input  logic                      spi_busy_i,
  input  logic                      spi_done_i,
  input  logic [7:0]                spi_rx_i
);

  localparam int unsigned TextW = TEXT_BYTES * 8;
  localparam int unsigned KeyW  = KEY_MAX * 8;
  localparam int unsigned CntW  = 7;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TextW-1:0]  text_q, text_d;
  logic [KeyW-1:0]   key_q, key_d;
  logic [7:0]        ksz_q, ksz_d;
  logic [TextW-1:0]  shadow_q, shadow_d;
  logic [TextW-1:0]  result_q, result_d;
  logic              busy_q, busy_d;
  logic              rv_q, rv_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic [7:0]        tx_q, tx_d;

  logic              key_ok_c;
  logic [CntW-1:0]   rx_start_c;
  logic [CntW-1:0]   last_idx_c;

  assign key_ok_c   = (key_size_i == 8'd16) || (key_size_i == 8'd24) || (key_size_i == 8'd32);
  // First receive byte index and final frame byte index for the latched key length
  assign rx_start_c = CntW'(TEXT_BYTES) + CntW'(1) + CntW'(ksz_q);
  assign last_idx_c = rx_start_c + CntW'(TEXT_BYTES) - CntW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    text_d   = text_q;
    key_d    = key_q;
    ksz_d    = ksz_q;
    shadow_d = shadow_q;
    result_d = result_q;
    busy_d   = busy_q;
    tx_d     = tx_q;
    rv_d     = 1'b0;
    err_d    = 1'b0;
    start_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // busy_q is still high in the cycle after FINISH, so a req there is dropped
        if (req_i && !busy_q) begin
          if (!key_ok_c) begin
            err_d = 1'b1;
          end else begin
            text_d   = text_in_i;
            key_d    = key_in_i;
            ksz_d    = key_size_i;
            shadow_d = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!spi_busy_i) begin
          start_d = 1'b1;
          state_d = WAIT;
          if (cnt_q < CntW'(TEXT_BYTES)) begin
            tx_d   = text_q[TextW-1 -: 8];
            text_d = text_q << 8;
          end else if (cnt_q == CntW'(TEXT_BYTES)) begin
            tx_d = ksz_q;
          end else if (cnt_q < rx_start_c) begin
            tx_d  = key_q[KeyW-1 -: 8];
            key_d = key_q << 8;
          end else begin
            tx_d = DUMMY_BYTE;
          end
        end
      end
      WAIT: begin
        // A done coincident with our own start pulse belongs to no issued byte
        if (spi_done_i && !start_q) begin
          if (cnt_q >= rx_start_c) begin
            shadow_d = {shadow_q[TextW-9:0], spi_rx_i};
          end
          cnt_d   = cnt_q + CntW'(1);
          state_d = (cnt_q == last_idx_c) ? FINISH : ISSUE;
        end
      end
      FINISH: begin
        result_d = shadow_q;
        rv_d     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      text_q   <= '0;
      key_q    <= '0;
      ksz_q    <= '0;
      shadow_q <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      tx_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      text_q   <= text_d;
      key_q    <= key_d;
      ksz_q    <= ksz_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      start_q  <= start_d;
      tx_q     <= tx_d;
    end
  end

  assign busy_o         = busy_q;
  assign result_valid_o = rv_q;
  assign result_o       = result_q;
  assign err_o          = err_q;
  assign spi_start_o    = start_q;
  assign spi_tx_o       = tx_q;

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Bench for aes_spi_sequencer: behavioural SPI master plus a frame-level reference model.
module tb_aes_spi_sequencer;

  logic         clk;
  logic         rst_n;
  logic         req;
  logic [7:0]   key_size;
  logic [127:0] text_in;
  logic [255:0] key_in;
  logic         busy;
  logic         result_valid;
  logic [127:0] result;
  logic         err;
  logic         spi_start;
  logic [7:0]   spi_tx;
  logic         spi_busy;
  logic         spi_done;
  logic [7:0]   spi_rx;

  aes_spi_sequencer dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .key_size_i     (key_size),
    .text_in_i      (text_in),
    .key_in_i       (key_in),
    .busy_o         (busy),
    .result_valid_o (result_valid),
    .result_o       (result),
    .err_o          (err),
    .spi_start_o    (spi_start),
    .spi_tx_o       (spi_tx),
    .spi_busy_i     (spi_busy),
    .spi_done_i     (spi_done),
    .spi_rx_i       (spi_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference frame and master-side bookkeeping
  logic [7:0]   exp_tx[$];
  logic [7:0]   tx_log[$];
  int           start_cnt = 0;
  int           serve_idx = 0;
  int           n_exp = 0;
  int           stall_at = -1;
  logic [127:0] resp_g = '0;

  localparam logic [127:0] T_TEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] T_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] T1_RES = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] T2_RES = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected mosi sequence from the transaction contents
  task automatic build_frame(input logic [7:0] ks, input logic [127:0] t, input logic [255:0] k);
    exp_tx.delete();
    for (int i = 0; i < 16; i++) exp_tx.push_back(t[127-8*i -: 8]);
    exp_tx.push_back(ks);
    for (int i = 0; i < int'(ks); i++) exp_tx.push_back(k[255-8*i -: 8]);
    for (int i = 0; i < 16; i++) exp_tx.push_back(8'h00);
    n_exp = 33 + int'(ks);
  endtask

  // Start monitor: every issued byte is compared against the reference frame
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && spi_start) begin
        tx_log.push_back(spi_tx);
        if (start_cnt < exp_tx.size())
          check($sformatf("tx_byte%0d", start_cnt), 256'(spi_tx), 256'(exp_tx[start_cnt]));
        start_cnt++;
      end
    end
  end

  // Behavioural SPI master: random latency, optional spurious done, optional busy stall
  int         m_lat;
  bit         m_abort;
  logic [7:0] m_hold;
  initial begin
    spi_busy = 1'b0;
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (rst_n && spi_start) begin
        m_lat   = $urandom_range(1, 4);
        m_abort = 1'b0;
        spi_busy = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          spi_done = 1'b1;
          spi_rx   = 8'($urandom);
        end
        for (int i = 0; i < m_lat && !m_abort; i++) begin
          @(negedge clk);
          spi_done = 1'b0;
          if (!rst_n) m_abort = 1'b1;
          else check("start_in_wait", 256'(spi_start), 256'(0));
        end
        if (!m_abort) begin
          if (serve_idx >= n_exp - 16)
            spi_rx = resp_g[127-8*(serve_idx-(n_exp-16)) -: 8];
          else
            spi_rx = 8'($urandom);
          spi_done = 1'b1;
          if (serve_idx == stall_at) begin
            m_hold = spi_tx;
            for (int i = 0; i < 5 && !m_abort; i++) begin
              @(negedge clk);
              spi_done = 1'b0;
              if (!rst_n) m_abort = 1'b1;
              else begin
                check("stall_no_start", 256'(spi_start), 256'(0));
                check("stall_tx_stable", 256'(spi_tx), 256'(m_hold));
              end
            end
          end
          serve_idx++;
        end
        spi_busy = 1'b0;
      end
    end
  end

  // One transaction; abort_at > 0 pulls reset once that many bytes have been issued
  task automatic run_txn(input logic [7:0] ks, input logic [127:0] t, input logic [255:0] k,
                         input logic [127:0] resp, input bit inject, input int abort_at);
    int  cyc;
    bit  got;
    build_frame(ks, t, k);
    tx_log.delete();
    resp_g    = resp;
    start_cnt = 0;
    serve_idx = 0;
    @(negedge clk);
    req = 1'b1; key_size = ks; text_in = t; key_in = k;
    @(negedge clk);
    req = 1'b0; text_in = rand128(); key_in = {rand128(), rand128()}; key_size = 8'd24;
    check("busy_after_accept", 256'(busy), 256'(1));
    cyc = 0;
    got = 1'b0;
    while (cyc < 3000 && !got) begin
      if (inject && cyc == 40) begin
        req = 1'b1; text_in = ~t; key_size = 8'd16;
      end else req = 1'b0;
      @(negedge clk);
      cyc++;
      if (abort_at > 0 && start_cnt >= abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_ctrl", 256'({busy, result_valid, err, spi_start, spi_tx}), 256'(0));
        check("abort_result", 256'(result), 256'(0));
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_result", 256'(result), 256'(0));
        check("post_abort_busy", 256'(busy), 256'(0));
        return;
      end
      if (result_valid) got = 1'b1;
      else check("busy_in_flight", 256'(busy), 256'(1));
    end
    req = 1'b0;
    check("rv_seen", 256'(got), 256'(1));
    if (got) begin
      check("result", 256'(result), 256'(resp));
      check("busy_at_rv", 256'(busy), 256'(1));
      check("start_count", 256'(start_cnt), 256'(n_exp));
      @(negedge clk);
      check("rv_one_cycle", 256'(result_valid), 256'(0));
      check("busy_released", 256'(busy), 256'(0));
      check("result_held", 256'(result), 256'(resp));
    end
  endtask

  task automatic bad_req(input logic [7:0] ks);
    start_cnt = 0;
    exp_tx.delete();
    @(negedge clk);
    req = 1'b1; key_size = ks;
    @(negedge clk);
    req = 1'b0;
    check($sformatf("err_pulse_ks%0d", ks), 256'(err), 256'(1));
    check("err_busy_low", 256'(busy), 256'(0));
    @(negedge clk);
    check("err_one_cycle", 256'(err), 256'(0));
    repeat (6) @(negedge clk);
    check("err_no_start", 256'(start_cnt), 256'(0));
  endtask

  initial begin
    logic [7:0]   ks;
    logic [7:0]   bad_list[5];
    bad_list = '{8'd20, 8'd0, 8'd17, 8'd33, 8'hff};
    rst_n = 1'b0; req = 1'b0; key_size = 8'h00; text_in = '0; key_in = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 256'({busy, result_valid, err, spi_start, spi_tx}), 256'(0));
    check("reset_result", 256'(result), 256'(0));
    rst_n = 1'b1;

    run_txn(8'd32, T_TEXT, T_KEY, T1_RES, 1'b0, 0);
    run_txn(8'd16, T_TEXT, {T_KEY[255:128], rand128()}, T2_RES, 1'b0, 0);
    check("t2_keysize_byte", 256'(tx_log[16]), 256'(8'h10));
    foreach (bad_list[i]) bad_req(bad_list[i]);
    run_txn(8'd32, T_TEXT, T_KEY, T1_RES, 1'b1, 0);
    run_txn(8'd32, T_TEXT, T_KEY, T1_RES, 1'b0, 30);
    run_txn(8'd32, T_TEXT, T_KEY, T1_RES, 1'b0, 0);
    stall_at = 10;
    run_txn(8'd32, T_TEXT, T_KEY, T1_RES, 1'b0, 0);
    stall_at = -1;

    for (int n = 0; n < 6; n++) begin
      case ($urandom_range(0, 2))
        0:       ks = 8'd16;
        1:       ks = 8'd24;
        default: ks = 8'd32;
      endcase
      stall_at = (n % 2 == 0) ? int'($urandom_range(0, 47)) : -1;
      run_txn(ks, rand128(), {rand128(), rand128()}, rand128(), n == 3, 0);
    end
    stall_at = -1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
